// File: rtl/jpeg_enc_pkg.sv
// Shared state encoding, address map and fdtbl address helper for the JPEG data-unit sequencer.
package jpeg_enc_pkg;

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_WR_U = 2'd1;
  localparam logic [1:0] S_WR_V = 2'd2;
  localparam logic [1:0] S_READ = 2'd3;

  localparam int unsigned DU_SIZE  = 64;
  localparam int unsigned DU_WORDS = 192;

  localparam logic [7:0] Y_BASE = 8'd0;
  localparam logic [7:0] U_BASE = 8'd64;
  localparam logic [7:0] V_BASE = 8'd128;

  localparam logic [6:0] FDTBL_UV_BASE = 7'd64;

  // U and V share the chroma table, so both fold onto the upper ROM half.
  function automatic logic [6:0] fdtbl_addr(input logic [7:0] ar);
    return (ar >= U_BASE) ? (FDTBL_UV_BASE | {1'b0, ar[5:0]}) : {1'b0, ar[5:0]};
  endfunction

endpackage

// File: rtl/jpeg_du_rd_pipe.sv
// Read side of the data-unit sequencer: issue/out pointers, valid/ready stall handling and the
// RAM read-address mux.
module jpeg_du_rd_pipe
  import jpeg_enc_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       active,
  input  logic       o_ready,
  output logic       o_valid,
  output logic [7:0] out_ptr,
  output logic [7:0] du_ram_ar,
  output logic       last_acc
);

  logic [7:0] issue_ptr;
  logic       issue;

  assign issue     = active && (issue_ptr < 8'(DU_WORDS)) && (!o_valid || o_ready);
  // A stall re-reads out_ptr so the registered RAM/ROM data holds steady.
  assign du_ram_ar = issue ? issue_ptr : out_ptr;
  assign last_acc  = active && o_valid && o_ready && (out_ptr == 8'(DU_WORDS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_ptr <= 8'd0;
      out_ptr   <= 8'd0;
      o_valid   <= 1'b0;
    end else if (clear || last_acc) begin
      issue_ptr <= 8'd0;
      out_ptr   <= 8'd0;
      o_valid   <= 1'b0;
    end else if (issue) begin
      out_ptr   <= issue_ptr;
      issue_ptr <= issue_ptr + 8'd1;
      o_valid   <= 1'b1;
    end else if (o_ready) begin
      o_valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/jpeg_du_ctrl.sv
// Data-unit sequencer: fills the 192x8 DU RAM with one 8x8 YUV block, then streams it with fdtbl
// entries to the DCT stage. Define JPEG_DU_LEVEL_SHIFT_EN to emit level-shifted samples.
module jpeg_du_ctrl
  import jpeg_enc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [7:0]       pix_y,
  input  logic [7:0]       pix_u,
  input  logic [7:0]       pix_v,
  output logic [7:0]       du_ram_aw,
  output logic [7:0]       du_ram_di,
  output logic             du_ram_we,
  output logic [7:0]       du_ram_ar,
  input  logic [7:0]       du_ram_do,
  output logic [6:0]       fdtbl_rom_a,
  input  logic [7:0]       fdtbl_rom_d,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [7:0]       o_sample,
  output logic [7:0]       o_qscale,
  output logic [1:0]       o_comp,
  output logic [5:0]       o_idx,
  output logic             o_last,
  output logic             du_done,
  output logic [CNT_W-1:0] du_count
);

  logic [1:0] state;
  logic [5:0] pix_idx;
  logic [7:0] u_hold;
  logic [7:0] v_hold;
  logic       pix_acc;
  logic       last_acc;
  logic [7:0] out_ptr;

  assign pix_ready = (state == S_FILL);
  assign pix_acc   = pix_valid && pix_ready && !flush;
  assign du_done   = last_acc && !flush;

  always_comb begin
    du_ram_we = 1'b0;
    du_ram_aw = 8'd0;
    du_ram_di = 8'd0;
    if (!flush) begin
      case (state)
        S_FILL: begin
          du_ram_we = pix_acc;
          du_ram_aw = pix_acc ? Y_BASE + {2'b00, pix_idx} : 8'd0;
          du_ram_di = pix_acc ? pix_y : 8'd0;
        end
        S_WR_U: begin
          du_ram_we = 1'b1;
          du_ram_aw = U_BASE + {2'b00, pix_idx};
          du_ram_di = u_hold;
        end
        S_WR_V: begin
          du_ram_we = 1'b1;
          du_ram_aw = V_BASE + {2'b00, pix_idx};
          du_ram_di = v_hold;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_FILL;
      pix_idx  <= 6'd0;
      u_hold   <= 8'd0;
      v_hold   <= 8'd0;
      du_count <= '0;
    end else if (flush) begin
      state   <= S_FILL;
      pix_idx <= 6'd0;
    end else begin
      case (state)
        S_FILL: begin
          if (pix_acc) begin
            u_hold <= pix_u;
            v_hold <= pix_v;
            state  <= S_WR_U;
          end
        end
        S_WR_U: state <= S_WR_V;
        S_WR_V: begin
          if (pix_idx == 6'(DU_SIZE - 1)) begin
            pix_idx <= 6'd0;
            state   <= S_READ;
          end else begin
            pix_idx <= pix_idx + 6'd1;
            state   <= S_FILL;
          end
        end
        default: begin
          if (last_acc) begin
            state    <= S_FILL;
            du_count <= du_count + CNT_W'(1);
          end
        end
      endcase
    end
  end

  jpeg_du_rd_pipe u_rd_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (flush),
    .active    (state == S_READ),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .out_ptr   (out_ptr),
    .du_ram_ar (du_ram_ar),
    .last_acc  (last_acc)
  );

  assign fdtbl_rom_a = fdtbl_addr(du_ram_ar);
  assign o_qscale    = fdtbl_rom_d;
  assign o_comp      = out_ptr[7:6];
  assign o_idx       = out_ptr[5:0];
  assign o_last      = (out_ptr[5:0] == 6'd63);

`ifdef JPEG_DU_LEVEL_SHIFT_EN
  assign o_sample = du_ram_do ^ 8'h80;
`else
  assign o_sample = du_ram_do;
`endif

endmodule

// File: tb/tb_jpeg_du_ctrl.sv
// Scoreboard bench for jpeg_du_ctrl: behavioural RAM/ROM, write and output monitors, directed DUs.
module tb_jpeg_du_ctrl;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             flush = 1'b0;
  logic             pix_valid = 1'b0;
  logic             pix_ready;
  logic [7:0]       pix_y = 8'd0;
  logic [7:0]       pix_u = 8'd0;
  logic [7:0]       pix_v = 8'd0;
  logic [7:0]       du_ram_aw;
  logic [7:0]       du_ram_di;
  logic             du_ram_we;
  logic [7:0]       du_ram_ar;
  logic [7:0]       du_ram_do = 8'd0;
  logic [6:0]       fdtbl_rom_a;
  logic [7:0]       fdtbl_rom_d = 8'd0;
  logic             o_valid;
  logic             o_ready = 1'b1;
  logic [7:0]       o_sample;
  logic [7:0]       o_qscale;
  logic [1:0]       o_comp;
  logic [5:0]       o_idx;
  logic             o_last;
  logic             du_done;
  logic [CNT_W-1:0] du_count;

  always #5 clk = ~clk;

  jpeg_du_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_y       (pix_y),
    .pix_u       (pix_u),
    .pix_v       (pix_v),
    .du_ram_aw   (du_ram_aw),
    .du_ram_di   (du_ram_di),
    .du_ram_we   (du_ram_we),
    .du_ram_ar   (du_ram_ar),
    .du_ram_do   (du_ram_do),
    .fdtbl_rom_a (fdtbl_rom_a),
    .fdtbl_rom_d (fdtbl_rom_d),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .o_sample    (o_sample),
    .o_qscale    (o_qscale),
    .o_comp      (o_comp),
    .o_idx       (o_idx),
    .o_last      (o_last),
    .du_done     (du_done),
    .du_count    (du_count)
  );

  function automatic logic [7:0] pval(input int pat, input int comp, input int i);
    case (pat)
      0: return 8'(comp * 64 + i);
      1: begin
        if (comp == 0) return 8'(255 - i);
        else if (comp == 1) return 8'(i * 4);
        else return 8'(i * 3 + 7);
      end
      default: return 8'(i * 7 + comp * 31 + 5);
    endcase
  endfunction

  function automatic logic [7:0] rom_val(input logic [6:0] a);
    return 8'(int'(a) * 5 + 3);
  endfunction

  // Behavioural memories with 1-cycle registered read.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (du_ram_we) ram[du_ram_aw] <= du_ram_di;
    du_ram_do   <= ram[du_ram_ar];
    fdtbl_rom_d <= rom_val(fdtbl_rom_a);
  end

  typedef struct packed {
    logic [7:0] sample;
    logic [7:0] qscale;
    logic [1:0] comp;
    logic [5:0] idx;
    logic       last;
    logic       done;
  } exp_t;

  typedef struct packed {
    logic [7:0] aw;
    logic [7:0] di;
  } wr_t;

  exp_t sb_q[$];
  wr_t  wr_q[$];

  int n_checks = 0;
  int n_pass = 0;
  int n_acc = 0;
  int n_wr = 0;
  int n_done = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: pop on every handshake and verify payload holds during stalls.
  exp_t        mon_e;
  logic        held_v = 1'b0;
  logic [24:0] held_p = '0;
  always @(negedge clk) begin
    if (reset_n && !flush) begin
      if (held_v)
        check("stall_stable", 32'({o_valid, o_sample, o_qscale, o_comp, o_idx, o_last}),
              32'({1'b1, held_p}));
      if (o_valid && o_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_sample", 32'(1), 32'(0));
        end else begin
          mon_e = sb_q.pop_front();
          check("sample", 32'({o_sample, o_qscale, o_comp, o_idx, o_last, du_done}),
                32'(mon_e));
        end
        n_acc++;
        held_v = 1'b0;
      end else if (o_valid) begin
        held_v = 1'b1;
        held_p = {o_sample, o_qscale, o_comp, o_idx, o_last};
      end else begin
        held_v = 1'b0;
      end
      if (du_done) n_done++;
    end else begin
      held_v = 1'b0;
    end
  end

  // Write monitor.
  wr_t wr_e;
  always @(negedge clk) begin
    if (reset_n && du_ram_we) begin
      n_wr++;
      if (wr_q.size() == 0) begin
        check("unexpected_write", 32'(1), 32'(0));
      end else begin
        wr_e = wr_q.pop_front();
        check("ram_write", 32'({du_ram_aw, du_ram_di}), 32'(wr_e));
      end
    end
  end

  task automatic push_du(input int pat);
    exp_t e;
    for (int k = 0; k < 192; k++) begin
      int comp;
      int i;
      comp     = k / 64;
      i        = k % 64;
      e.sample = pval(pat, comp, i);
`ifdef JPEG_DU_LEVEL_SHIFT_EN
      e.sample = e.sample ^ 8'h80;
`endif
      e.qscale = rom_val(7'((comp == 0) ? i : 64 + i));
      e.comp   = 2'(comp);
      e.idx    = 6'(i);
      e.last   = (i == 63);
      e.done   = (k == 191);
      sb_q.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_pixel(input int pat, input int i);
    int w;
    pix_y     = pval(pat, 0, i);
    pix_u     = pval(pat, 1, i);
    pix_v     = pval(pat, 2, i);
    pix_valid = 1'b1;
    wr_q.push_back({8'(i), pix_y});
    wr_q.push_back({8'(64 + i), pix_u});
    wr_q.push_back({8'(128 + i), pix_v});
    w = 0;
    @(negedge clk);
    while (!pix_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) check("pix_ready_timeout", 32'(0), 32'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic fill_du(input int pat, input bit keep_valid);
    for (int i = 0; i < 64; i++) send_pixel(pat, i);
    if (keep_valid) begin
      pix_y = 8'hEE;
      pix_u = 8'hDD;
      pix_v = 8'hCC;
    end else begin
      pix_valid = 1'b0;
    end
    push_du(pat);
  endtask

  task automatic wait_drain(input string name, output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      cnt++;
    end while (sb_q.size() != 0 && cnt < 3000);
    #1;
    check(name, 32'(sb_q.size()), 32'(0));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pix_ready"}, 32'(pix_ready), 32'(1));
    check({tag, "_o_valid"}, 32'(o_valid), 32'(0));
    check({tag, "_we"}, 32'(du_ram_we), 32'(0));
    check({tag, "_du_done"}, 32'(du_done), 32'(0));
    check({tag, "_du_count"}, 32'(du_count), 32'(0));
    check({tag, "_aw_di_ar"}, 32'({du_ram_aw, du_ram_di, du_ram_ar}), 32'(0));
    check({tag, "_rom_a"}, 32'(fdtbl_rom_a), 32'(0));
    check({tag, "_comp_idx"}, 32'({o_comp, o_idx}), 32'(0));
  endtask

  initial begin
    int c0;
    int w0;
    int d0;
    int a0;
    int cnt;

    #1 reset_n = 1'b0;
    #1 check_reset("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // DU A: identity pattern, o_ready held high.
    c0 = cyc;
    w0 = n_wr;
    fill_du(0, 1'b0);
    check("du_a_fill_cycles", 32'(cyc - c0), 32'(190));
    wait_drain("du_a_drain", cnt);
    check("du_a_latency", 32'(cnt), 32'(195));
    check("du_a_writes", 32'(n_wr - w0), 32'(192));
    check("du_a_done", 32'(n_done), 32'(1));
    check("du_a_count", 32'(du_count), 32'(1));
    check("du_a_idle_ready", 32'(pix_ready), 32'(1));

    // DU B: pix_valid held outside S_FILL, 1010 then random o_ready.
    w0 = n_wr;
    fill_du(1, 1'b1);
    cnt = 0;
    while (sb_q.size() != 0 && cnt < 3000) begin
      o_ready = (cnt < 16) ? ~cnt[0] : 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == 1) check("pix_ready_in_wr_v", 32'(pix_ready), 32'(0));
      if (cnt == 5) check("pix_ready_in_read", 32'(pix_ready), 32'(0));
    end
    check("du_b_drain", 32'(sb_q.size()), 32'(0));
    o_ready   = 1'b1;
    pix_valid = 1'b0;
    @(posedge clk);
    #1;
    check("du_b_writes", 32'(n_wr - w0), 32'(192));
    check("du_b_done", 32'(n_done), 32'(2));
    check("du_b_count", 32'(du_count), 32'(2));

    // DU C: flush after 100 accepted samples.
    fill_du(2, 1'b0);
    a0  = n_acc;
    d0  = n_done;
    cnt = 0;
    while (n_acc - a0 < 100 && cnt < 1000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("flush_reach_100", 32'(n_acc - a0), 32'(100));
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    sb_q.delete();
    check("flush_o_valid", 32'(o_valid), 32'(0));
    check("flush_du_done", 32'(du_done), 32'(0));
    check("flush_du_count", 32'(du_count), 32'(2));
    check("flush_pix_ready", 32'(pix_ready), 32'(1));
    check("flush_comp_idx", 32'({o_comp, o_idx}), 32'(0));
    repeat (3) @(posedge clk);
    #1;
    check("flush_no_done", 32'(n_done - d0), 32'(0));

    // DU D: full DU after flush.
    fill_du(0, 1'b0);
    wait_drain("du_d_drain", cnt);
    check("du_d_done", 32'(n_done - d0), 32'(1));
    check("du_d_count", 32'(du_count), 32'(3));

    // Async reset with pix_idx at 30.
    for (int i = 0; i < 30; i++) send_pixel(2, i);
    pix_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_writes", 32'(wr_q.size()), 32'(0));
    reset_n = 1'b0;
    #1 check_reset("mid_reset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    d0 = n_done;
    w0 = n_wr;
    fill_du(1, 1'b0);
    wait_drain("du_e_drain", cnt);
    check("du_e_writes", 32'(n_wr - w0), 32'(192));
    check("du_e_done", 32'(n_done - d0), 32'(1));
    check("du_e_count", 32'(du_count), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
